// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master read sequencer.
//   state_e  : sequencer states, in transaction order
//   ACK/NACK : value of the acknowledge bit on the bus (ACK drives SDA low)
//   RW_READ  : R/W bit that follows the 7-bit slave address for a read
//   addr_byte: builds the first byte sent on the bus from a 7-bit address
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_ADDR     = 3'd2,
        ST_ADDR_ACK = 3'd3,
        ST_READ     = 3'd4,
        ST_MACK     = 3'd5,
        ST_STOP     = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr);
        return {addr, RW_READ};
    endfunction

endpackage

// File: rtl/i2c_rx_shift.sv
// MSB-first serial-to-parallel assembler for bytes read from the slave.
// Ports:
//   clock_i   : system clock
//   reset_i   : synchronous active-high reset
//   load_i    : bit_i holds the next serial bit (MSB first)
//   bit_i     : serial data bit
//   capture_i : byte boundary; the bit loaded in the same cycle is included
//   data_o    : last captured byte, held until the next capture
//   valid_o   : one-cycle pulse in the cycle after a capture
module i2c_rx_shift (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       bit_i,
    input  logic       capture_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [7:0] sr_q, sr_d;
    logic [7:0] data_q;
    logic       valid_q;

    // The captured byte is taken from sr_d so that a final bit arriving
    // together with the capture strobe is part of the byte.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = {sr_q[6:0], bit_i};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            valid_q <= capture_i;
            if (capture_i) begin
                data_q <= sr_d;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/i2c_master_read_seq.sv
// I2C master read-transaction sequencer: START, address+R, slave ACK check,
// N data bytes each followed by a master ACK (NACK on the last), STOP.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : host command; accepted only in IDLE
//   cmd_addr, cmd_len        : 7-bit slave address, byte count (0 = probe)
//   rx_data, rx_valid        : assembled byte and its one-cycle strobe
//   done, nack_err           : end-of-transaction pulse, address NACK flag
//   start_*/stop_*/wbyte_*/ack_*/rbyte_*/mack_* : bit/byte primitives
//
// Primitive handshake: a state that uses a primitive holds its *_go high for
// the whole time the FSM sits in that state. The primitive pulses *_finish
// once; the FSM leaves on the next clock edge, which drops *_go. A *_finish
// seen in any state other than the owning one has no effect. All *_go
// outputs are pure decodes of the state register, so no *_finish reaches a
// *_go combinationally.
module i2c_master_read_seq
    import i2c_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             done,
    output logic             nack_err,
    output logic             start_go,
    input  logic             start_finish,
    output logic             stop_go,
    input  logic             stop_finish,
    output logic             wbyte_go,
    output logic [7:0]       wbyte_data,
    input  logic             wbyte_finish,
    output logic             ack_go,
    input  logic             ack_value,
    input  logic             ack_finish,
    output logic             rbyte_go,
    input  logic             rbyte_bit,
    input  logic             rbyte_load,
    input  logic             rbyte_finish,
    output logic             mack_go,
    output logic             mack_bit,
    input  logic             mack_finish
);

    state_e           state_q, state_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wbyte_q <= 8'h00;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wbyte_q <= wbyte_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wbyte_d = wbyte_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wbyte_d = addr_byte(cmd_addr);
                    rem_d   = cmd_len;
                    err_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (start_finish) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (wbyte_finish) state_d = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                if (ack_finish) begin
                    if (ack_value == NACK) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (rem_q == '0) begin
                        state_d = ST_STOP;     // address probe, no data phase
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rbyte_finish) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = ST_MACK;
                end
            end
            ST_MACK: begin
                if (mack_finish) begin
                    state_d = (rem_q != '0) ? ST_READ : ST_STOP;
                end
            end
            ST_STOP: begin
                if (stop_finish) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign start_go   = (state_q == ST_START);
    assign wbyte_go   = (state_q == ST_ADDR);
    assign ack_go     = (state_q == ST_ADDR_ACK);
    assign rbyte_go   = (state_q == ST_READ);
    assign mack_go    = (state_q == ST_MACK);
    assign stop_go    = (state_q == ST_STOP);
    assign done       = (state_q == ST_DONE);
    assign nack_err   = (state_q == ST_DONE) && err_q;
    assign wbyte_data = wbyte_q;

    // rem_q already counts the byte just read, so reaching zero here means
    // the byte being acknowledged is the last one and gets a NACK.
    assign mack_bit   = (rem_q == '0) ? NACK : ACK;

    i2c_rx_shift u_rx_shift (
        .clock_i   (clock),
        .reset_i   (reset),
        .load_i    ((state_q == ST_READ) && rbyte_load),
        .bit_i     (rbyte_bit),
        .capture_i ((state_q == ST_READ) && rbyte_finish),
        .data_o    (rx_data),
        .valid_o   (rx_valid)
    );

endmodule
